// File: rtl/pokey_bus_capture.sv
// Cartridge-bus write capture for the POKEY window: synchronises the async bus, detects
// qualified phi2 falls and queues (addr, data) in a small FIFO. Optional debug: CAPTURE_DEBUG_EN.
module pokey_bus_capture #(
    parameter logic [11:0] BASE_HI     = 12'h045,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_HIGH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_a,
    input  logic [7:0]  bus_d,
    input  logic        bus_phi2,
    input  logic        bus_rw,
    input  logic        bus_halt,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [3:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic        overflow
`ifdef CAPTURE_DEBUG_EN
    ,
    output logic [7:0]  dbg_drop_cnt,
    output logic [11:0] dbg_last_wr
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int HW = $clog2(MIN_HIGH + 1);

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        phi2;
        logic        rw;
        logic        halt;
    } bus_t;

    bus_t                    bus_in;
    bus_t [SYNC_STAGES-1:0]  sync_q;
    bus_t                    bus_dly;
    logic [HW-1:0]           hcnt;
    logic                    phi2_s;
    logic                    fall, qual;

    assign bus_in = {bus_a, bus_d, bus_phi2, bus_rw, bus_halt};
    assign phi2_s = sync_q[SYNC_STAGES-1].phi2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            bus_dly <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus_in};
            bus_dly <= sync_q[SYNC_STAGES-1];
        end
    end

    // Counts synced phi2-high cycles; a fall only counts once the pulse was long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hcnt <= '0;
        else if (!phi2_s)
            hcnt <= '0;
        else if (hcnt != HW'(MIN_HIGH))
            hcnt <= hcnt + 1'b1;
    end

    assign fall = bus_dly.phi2 & ~phi2_s & (hcnt == HW'(MIN_HIGH));
    assign qual = fall & ~bus_dly.rw & bus_dly.halt & (bus_dly.a[15:4] == BASE_HI);

    logic       ev_vld;
    logic [3:0] ev_addr;
    logic [7:0] ev_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_vld  <= 1'b0;
            ev_addr <= '0;
            ev_data <= '0;
        end else begin
            ev_vld <= qual;
            if (qual) begin
                ev_addr <= bus_dly.a[3:0];
                ev_data <= bus_dly.d;
            end
        end
    end

    logic [FIFO_DEPTH-1:0][11:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [LW-1:0]               level;
    logic                        full, pop, push, drop;

    assign full  = (level == LW'(FIFO_DEPTH));
    assign pop   = wr_valid & wr_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push  = ev_vld & (~full | pop);
    assign drop  = ev_vld & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {ev_addr, ev_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop)
                overflow <= 1'b1;
        end
    end

    assign wr_valid           = (level != '0);
    assign {wr_addr, wr_data} = mem[rd_ptr];
    assign fifo_level         = level;

`ifdef CAPTURE_DEBUG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_drop_cnt <= '0;
            dbg_last_wr  <= '0;
        end else begin
            if (drop && dbg_drop_cnt != 8'hFF)
                dbg_drop_cnt <= dbg_drop_cnt + 1'b1;
            if (ev_vld)
                dbg_last_wr <= {ev_addr, ev_data};
        end
    end
`endif

endmodule

// File: tb/tb_pokey_bus_capture.sv
// Directed bench for pokey_bus_capture: bus writes via phi2 pulses, checked with immediate assertions.
module tb_pokey_bus_capture;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_phi2, bus_rw, bus_halt;
    logic        wr_valid, wr_ready;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  fifo_level;
    logic        overflow;
`ifdef CAPTURE_DEBUG_EN
    logic [7:0]  dbg_drop_cnt;
    logic [11:0] dbg_last_wr;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pokey_bus_capture dut (
        .clk(clk), .reset(reset),
        .bus_a(bus_a), .bus_d(bus_d), .bus_phi2(bus_phi2), .bus_rw(bus_rw), .bus_halt(bus_halt),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .fifo_level(fifo_level), .overflow(overflow)
`ifdef CAPTURE_DEBUG_EN
        , .dbg_drop_cnt(dbg_drop_cnt), .dbg_last_wr(dbg_last_wr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [15:0] a, input logic [7:0] d, input logic rw,
                         input logic halt, input int n);
        @(negedge clk);
        bus_a = a; bus_d = d; bus_rw = rw; bus_halt = halt; bus_phi2 = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        bus_phi2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        pulse(a, d, 1'b0, 1'b1, 30);
        idle(10);
    endtask

    task automatic pop1();
        @(negedge clk); wr_ready = 1'b1;
        @(posedge clk); #1; wr_ready = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [7:0] first, input int n);
        @(negedge clk); wr_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(wr_valid), 32'd1);
            chk({tag, "_data"}, 32'(wr_data), 32'(first + 8'(i)));
            @(negedge clk);
        end
        wr_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(3);
        @(negedge clk); reset = 1'b0;
        idle(2);
    endtask

    initial begin
        bus_a = '0; bus_d = '0; bus_phi2 = 1'b0; bus_rw = 1'b1; bus_halt = 1'b1; wr_ready = 1'b0;
        do_reset();
        chk("rst_valid", 32'(wr_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_addr", 32'(wr_addr), 0);
        chk("rst_data", 32'(wr_data), 0);

        // Basic write plus latency from pin fall to wr_valid.
        pulse(16'h0452, 8'hA5, 1'b0, 1'b1, 30);
        idle(3);
        chk("lat_early", 32'(wr_valid), 0);
        idle(1);
        chk("lat_valid", 32'(wr_valid), 1);
        idle(6);
        chk("w1_addr", 32'(wr_addr), 2);
        chk("w1_data", 32'(wr_data), 32'hA5);
        chk("w1_level", 32'(fifo_level), 1);
        pop1();
        chk("w1_pop_level", 32'(fifo_level), 0);
        chk("w1_pop_valid", 32'(wr_valid), 0);

        // Non-qualifying cycles.
        pulse(16'h0452, 8'hA5, 1'b1, 1'b1, 30); idle(10);
        chk("read_ignored", 32'(fifo_level), 0);
        pulse(16'h0452, 8'hA5, 1'b0, 1'b0, 30); idle(10);
        chk("halt_ignored", 32'(fifo_level), 0);
        pulse(16'h0462, 8'hA5, 1'b0, 1'b1, 30); idle(10);
        chk("addr_ignored", 32'(fifo_level), 0);
        chk("ignored_valid", 32'(wr_valid), 0);

        // Glitch filtering and the MIN_HIGH boundary.
        pulse(16'h0451, 8'h11, 1'b0, 1'b1, 5); idle(10);
        chk("glitch5", 32'(fifo_level), 0);
        pulse(16'h0451, 8'h12, 1'b0, 1'b1, 7); idle(10);
        chk("glitch7", 32'(fifo_level), 0);
        pulse(16'h0451, 8'h13, 1'b0, 1'b1, 8); idle(10);
        chk("exact8_level", 32'(fifo_level), 1);
        chk("exact8_data", 32'(wr_data), 32'h13);
        pop1();
        wr(16'h0451, 8'h14);
        chk("after_glitch", 32'(fifo_level), 1);
        chk("after_glitch_data", 32'(wr_data), 32'h14);
        pop1();
        chk("after_glitch_pop", 32'(fifo_level), 0);

        // Overflow: five writes with no pops.
        for (int i = 1; i <= 5; i++) wr(16'h045F, 8'(i));
        chk("ovf_level", 32'(fifo_level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_head", 32'(wr_data), 32'h01);
        chk("ovf_addr", 32'(wr_addr), 32'hF);
        drain("ovf_drain", 8'h01, 4);
        idle(1);
        chk("ovf_empty", 32'(fifo_level), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Full FIFO with pop and push on the same edge.
        do_reset();
        chk("rst2_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) wr(16'h0453, 8'h11 + 8'(i));
        chk("same_pre_level", 32'(fifo_level), 4);
        pulse(16'h0453, 8'h15, 1'b0, 1'b1, 30);
        repeat (3) @(posedge clk);
        @(negedge clk); wr_ready = 1'b1;
        @(posedge clk); #1; wr_ready = 1'b0;
        chk("same_level", 32'(fifo_level), 4);
        chk("same_ovf", 32'(overflow), 0);
        chk("same_head", 32'(wr_data), 32'h12);
        drain("same_drain", 8'h12, 4);
        idle(1);
        chk("same_empty", 32'(fifo_level), 0);

        // Reset asserted in the middle of a phi2-high pulse.
        for (int i = 0; i < 3; i++) wr(16'h0454, 8'h30 + 8'(i));
        chk("mid_pre_level", 32'(fifo_level), 3);
        @(negedge clk);
        bus_a = 16'h0454; bus_d = 8'h3F; bus_rw = 1'b0; bus_halt = 1'b1; bus_phi2 = 1'b1;
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_valid", 32'(wr_valid), 0);
        chk("mid_level", 32'(fifo_level), 0);
        chk("mid_data", 32'(wr_data), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); bus_phi2 = 1'b0;
        idle(10);
        chk("mid_after_level", 32'(fifo_level), 0);
        chk("mid_after_valid", 32'(wr_valid), 0);

`ifdef CAPTURE_DEBUG_EN
        do_reset();
        chk("dbg_rst_cnt", 32'(dbg_drop_cnt), 0);
        for (int i = 1; i <= 6; i++) wr(16'h0450, 8'h20 + 8'(i));
        chk("dbg_drop_cnt", 32'(dbg_drop_cnt), 2);
        chk("dbg_last_wr", 32'(dbg_last_wr), 32'h026);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
